// File: rtl/mem_responder.sv
// Single-outstanding memory responder: word array plus an 8-bit output register,
// with IDLE -> ACCESS -> RESPOND sequencing and byte-lane stores.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] GPIO_ADDR   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_wsize,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [7:0]  gpio
);
    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
    state_t state, state_nxt;

    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    wsize_q;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          hit_mem, hit_gpio, size_bad, misaligned, is_load, err, take;
    logic          mem_we, gpio_we;
    logic [3:0]    lane_en;
    logic [31:0]   wr_word, rd_word, rd_shift, data_nxt;

    assign take       = req_valid && (state == IDLE);
    assign idx        = addr_q[AW+1:2];
    assign hit_gpio   = (addr_q == GPIO_ADDR);
    assign hit_mem    = ({2'b00, addr_q[31:2]} < DEPTH_L);
    assign is_load    = (wsize_q == 3'b000);
    assign size_bad   = ((wsize_q & (wsize_q - 3'd1)) != 3'd0);
    assign misaligned = ((wsize_q == 3'b010) && addr_q[0]) ||
                        ((wsize_q == 3'b001) && (addr_q[1:0] != 2'b00));
    assign err        = size_bad || misaligned || !(hit_gpio || hit_mem);

    // The output register takes priority should GPIO_ADDR ever fall inside the array.
    assign mem_we  = (state == ACCESS) && !is_load && !err && !hit_gpio;
    assign gpio_we = (state == ACCESS) && !is_load && !err && hit_gpio;

    always_comb begin
        lane_en = 4'b0000;
        wr_word = wdata_q;
        case (wsize_q)
            3'b100: begin
                lane_en = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            3'b010: begin
                lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            3'b001:  lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        data_nxt = 32'h0;
        if (!err && is_load)
            data_nxt = hit_gpio ? {24'h0, gpio} : rd_shift;
    end

    // Array has no reset; a reset during ACCESS forces IDLE, which kills mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wsize_q <= 3'b000;
        end else if (take) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wsize_q <= req_wsize;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
            gpio     <= 8'h00;
        end else begin
            if (state == ACCESS) begin
                rsp_data <= data_nxt;
                rsp_err  <= err;
            end
            if (gpio_we)
                gpio <= wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = ACCESS;
            end
            ACCESS: state_nxt = RESPOND;
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, is the number of 32-bit words in the internal data array (power of two).
REQ-002 Parameter GPIO_ADDR, default 32'h8000_0000, is the byte address of the output register.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wsize  input  3  store size, one-hot: 100 byte, 010 half, 001 word; 000 = load.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts the response.
REQ-012 rsp_data  output  32  load data, shifted right by 8*req_addr[1:0], zero-filled; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was rejected (misaligned, illegal size, unmapped).
REQ-014 gpio  output  8  output register contents.

Function
REQ-015 FSM states IDLE, ACCESS, RESPOND; reset state IDLE.
REQ-016 req_ready is 1 only in IDLE; handshake occurs when req_valid and req_ready are both 1 on a rising edge; addr, wsize and wdata are captured then; IDLE->ACCESS.
REQ-017 ACCESS lasts exactly one cycle: array read or lane-masked write is performed; ACCESS->RESPOND.
REQ-018 In RESPOND, rsp_valid=1 and rsp_data/rsp_err are held stable until rsp_ready=1; on that edge RESPOND->IDLE.
REQ-019 Minimum latency is 2 cycles from the handshake edge to rsp_valid; 1-cycle-later back-to-back acceptance after response completion (one request in flight, no pipelining).
REQ-020 Word index is addr[log2(DEPTH_WORDS)+1:2]; mapped when addr[31:2] < DEPTH_WORDS.
REQ-021 Byte store writes wdata[7:0] to lane addr[1:0]; half store writes wdata[15:0] to lanes addr[1]*2..+1; word store writes all lanes; other lanes unchanged.
REQ-022 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0: rsp_err=1, no write.
REQ-023 req_wsize with more than one bit set: rsp_err=1, no write.
REQ-024 Unmapped address (neither array nor GPIO_ADDR): rsp_err=1, no write, rsp_data=0.
REQ-025 GPIO_ADDR: any legal store writes wdata[7:0] to gpio; load returns {24'b0, gpio}.
REQ-026 req_valid while not in IDLE is ignored (not captured, not counted).
REQ-027 Array contents are not initialised and never cleared by reset.

Reset
REQ-028 rst_n=0 forces immediately: state IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, gpio=0, req_ready=1 once rst_n is released.
REQ-029 Reset asserted in ACCESS before the rising edge discards the pending store (array unchanged); reset in RESPOND drops the response.
REQ-030 First handshake is allowed on the first rising edge after rst_n deasserts.

Verification
REQ-031 Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> rsp_data=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each handshake.
REQ-032 After REQ-031, byte store 0x55 at 0x12, word load at 0x10 -> 0xDE55BEEF; byte load at 0x13 -> 0x000000DE.
REQ-033 Half store at 0x11 -> rsp_err=1; subsequent load at 0x10 is unchanged; wsize=110 -> rsp_err=1.
REQ-034 Store 0xA5 to GPIO_ADDR -> gpio=0xA5 after the ACCESS edge; load GPIO_ADDR -> 0x000000A5; load 0x4000_0000 -> rsp_err=1, rsp_data=0.
REQ-035 Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0, extra req_valid ignored; release -> IDLE next edge.
REQ-036 Assert rst_n=0 during ACCESS of a word store to 0x20 -> gpio=0, rsp_valid=0 immediately; later load 0x20 returns the prior value.
